// File: rtl/dma_timing_fsm.sv
// DMA service timing sequencer.
// Walks one channel service through hold request, address strobe, read/write
// command phases and the count update. Outputs are re-registered from the next
// state, so they always equal a decode of the current state plus the latched
// channel/type. EOP_out_n is the exception: it qualifies S4 with tc, which is
// only valid during that same cycle.
module dma_timing_fsm (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    input  logic [1:0] req_ch,
    input  logic       cmd_disable,
    input  logic [1:0] xfer_type,
    input  logic       blk_mode,
    input  logic       HLDA,
    input  logic       READY,
    input  logic       tc,
    input  logic       EOP_in_n,
    output logic       HRQ,
    output logic [3:0] dack_en,
    output logic       AEN,
    output logic       ADSTB,
    output logic       MEMR_n,
    output logic       MEMW_n,
    output logic       IOR_n,
    output logic       IOW_n,
    output logic       EOP_out_n,
    output logic       update,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_SW = 3'd5,
        ST_S4 = 3'd6
    } state_t;

    typedef struct packed {
        logic       hrq;
        logic [3:0] dack;
        logic       aen;
        logic       adstb;
        logic       memr_n;
        logic       memw_n;
        logic       ior_n;
        logic       iow_n;
        logic       upd;
        logic       bsy;
    } outs_t;

    // Maps a state and the latched channel/type onto the bus output set.
    function automatic outs_t decode_outputs(input state_t st,
                                             input logic [1:0] ch,
                                             input logic [1:0] ty);
        outs_t o;
        logic  is_write;
        logic  is_read;
        logic  rd_phase;
        logic  wr_phase;
        logic  on_bus;
        is_write = (ty == 2'b01);
        is_read  = (ty == 2'b10);
        rd_phase = 1'b0;
        wr_phase = 1'b0;
        on_bus   = 1'b0;
        o        = '0;
        case (st)
            ST_SI: begin
                on_bus = 1'b0;
            end
            ST_S0: begin
                o.hrq = 1'b1;
            end
            ST_S1: begin
                o.hrq   = 1'b1;
                on_bus  = 1'b1;
                o.adstb = 1'b1;
            end
            ST_S2: begin
                o.hrq    = 1'b1;
                on_bus   = 1'b1;
                rd_phase = 1'b1;
            end
            ST_S3, ST_SW: begin
                o.hrq    = 1'b1;
                on_bus   = 1'b1;
                rd_phase = 1'b1;
                wr_phase = 1'b1;
            end
            ST_S4: begin
                o.hrq  = 1'b1;
                on_bus = 1'b1;
                o.upd  = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        if (on_bus) begin
            o.aen  = 1'b1;
            o.dack = 4'b0001 << ch;
        end else begin
            o.aen  = 1'b0;
            o.dack = 4'b0000;
        end
        // Write moves I/O to memory (IOR then MEMW); read moves memory to I/O.
        o.ior_n  = ~(is_write & rd_phase);
        o.memw_n = ~(is_write & wr_phase);
        o.memr_n = ~(is_read & rd_phase);
        o.iow_n  = ~(is_read & wr_phase);
        o.bsy    = (st != ST_SI);
        return o;
    endfunction

    localparam outs_t IDLE_OUTS = decode_outputs(ST_SI, 2'b00, 2'b00);

    state_t     state_r;
    state_t     state_next_s;
    logic [1:0] ch_r;
    logic [1:0] ch_next_s;
    logic [1:0] type_r;
    logic [1:0] type_next_s;
    logic       blk_r;
    logic       blk_next_s;
    logic       eop_r;
    logic       eop_next_s;
    logic       eop_seen_s;
    logic       active_s;
    outs_t      outs_r;

    // Next-state, channel latch and end-of-process flag computation.
    always_comb begin
        state_next_s = state_r;
        ch_next_s    = ch_r;
        type_next_s  = type_r;
        blk_next_s   = blk_r;
        eop_next_s   = eop_r;
        // An EOP seen during the current S4 also ends the block.
        eop_seen_s   = eop_r | ~EOP_in_n;
        active_s     = 1'b0;
        case (state_r)
            ST_SI: begin
                if (req_valid && !cmd_disable) begin
                    ch_next_s    = req_ch;
                    type_next_s  = xfer_type;
                    blk_next_s   = blk_mode;
                    state_next_s = ST_S0;
                end else begin
                    state_next_s = ST_SI;
                end
            end
            ST_S0: begin
                if (HLDA) begin
                    state_next_s = ST_S1;
                end else begin
                    state_next_s = ST_S0;
                end
            end
            ST_S1: begin
                active_s = 1'b1;
                if (!HLDA) begin
                    state_next_s = ST_SI;
                end else begin
                    state_next_s = ST_S2;
                end
            end
            ST_S2: begin
                active_s = 1'b1;
                if (!HLDA) begin
                    state_next_s = ST_SI;
                end else begin
                    state_next_s = ST_S3;
                end
            end
            ST_S3, ST_SW: begin
                active_s = 1'b1;
                if (!HLDA) begin
                    state_next_s = ST_SI;
                end else if (!READY) begin
                    state_next_s = ST_SW;
                end else begin
                    state_next_s = ST_S4;
                end
            end
            ST_S4: begin
                active_s = 1'b1;
                if (tc || eop_seen_s || !blk_r) begin
                    state_next_s = ST_SI;
                end else begin
                    state_next_s = ST_S1;
                end
            end
            default: begin
                state_next_s = ST_SI;
            end
        endcase
        if (state_next_s == ST_SI) begin
            eop_next_s = 1'b0;
        end else if (active_s) begin
            eop_next_s = eop_seen_s;
        end else begin
            eop_next_s = eop_r;
        end
    end

    // State, latched service parameters and registered output decode.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_SI;
            ch_r    <= 2'b00;
            type_r  <= 2'b00;
            blk_r   <= 1'b0;
            eop_r   <= 1'b0;
            outs_r  <= IDLE_OUTS;
        end else begin
            state_r <= state_next_s;
            ch_r    <= ch_next_s;
            type_r  <= type_next_s;
            blk_r   <= blk_next_s;
            eop_r   <= eop_next_s;
            outs_r  <= decode_outputs(state_next_s, ch_next_s, type_next_s);
        end
    end

    assign HRQ       = outs_r.hrq;
    assign dack_en   = outs_r.dack;
    assign AEN       = outs_r.aen;
    assign ADSTB     = outs_r.adstb;
    assign MEMR_n    = outs_r.memr_n;
    assign MEMW_n    = outs_r.memw_n;
    assign IOR_n     = outs_r.ior_n;
    assign IOW_n     = outs_r.iow_n;
    assign update    = outs_r.upd;
    assign busy      = outs_r.bsy;
    assign EOP_out_n = ~((state_r == ST_S4) & tc);

endmodule

// File: tb/tb_dma_timing_fsm.sv
// Self-checking bench for dma_timing_fsm: directed service scenarios plus a
// randomized run compared against a phase-level reference model.
module tb_dma_timing_fsm;

    logic       CLK;
    logic       RESET;
    logic       req_valid;
    logic [1:0] req_ch;
    logic       cmd_disable;
    logic [1:0] xfer_type;
    logic       blk_mode;
    logic       HLDA;
    logic       READY;
    logic       tc;
    logic       EOP_in_n;
    logic       HRQ;
    logic [3:0] dack_en;
    logic       AEN;
    logic       ADSTB;
    logic       MEMR_n;
    logic       MEMW_n;
    logic       IOR_n;
    logic       IOW_n;
    logic       EOP_out_n;
    logic       update;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // {HRQ, dack_en, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, update, busy}
    logic [12:0] obs_v;
    assign obs_v = {HRQ, dack_en, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, update, busy};

    localparam logic [12:0] IDLE_V = 13'b0_0000_0_0_1111_0_0;

    // Reference model phases of one service.
    localparam int P_IDLE  = 0;
    localparam int P_HOLD  = 1;
    localparam int P_ADDR  = 2;
    localparam int P_RDCMD = 3;
    localparam int P_XFER  = 4;
    localparam int P_WAIT  = 5;
    localparam int P_DONE  = 6;

    dma_timing_fsm dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ch(req_ch),
        .cmd_disable(cmd_disable), .xfer_type(xfer_type), .blk_mode(blk_mode),
        .HLDA(HLDA), .READY(READY), .tc(tc), .EOP_in_n(EOP_in_n),
        .HRQ(HRQ), .dack_en(dack_en), .AEN(AEN), .ADSTB(ADSTB),
        .MEMR_n(MEMR_n), .MEMW_n(MEMW_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
        .EOP_out_n(EOP_out_n), .update(update), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        RESET = 1'b0; req_valid = 1'b0; req_ch = 2'd0; cmd_disable = 1'b0;
        xfer_type = 2'b00; blk_mode = 1'b0; HLDA = 1'b1; READY = 1'b1;
        tc = 1'b0; EOP_in_n = 1'b1;
    endtask

    // Expected bus outputs for a model phase with latched channel and type.
    function automatic logic [12:0] model_out(input int ph, input logic [1:0] ch, input logic [1:0] ty);
        logic wr, rd, on_bus, rd_cmd, wr_cmd;
        logic [3:0] dk;
        wr     = (ty == 2'b01);
        rd     = (ty == 2'b10);
        on_bus = (ph >= P_ADDR);
        rd_cmd = (ph == P_RDCMD) || (ph == P_XFER) || (ph == P_WAIT);
        wr_cmd = (ph == P_XFER) || (ph == P_WAIT);
        dk     = on_bus ? (4'b0001 << ch) : 4'b0000;
        return {ph != P_IDLE, dk, on_bus, ph == P_ADDR,
                !(rd && rd_cmd), !(wr && wr_cmd), !(wr && rd_cmd), !(rd && wr_cmd),
                ph == P_DONE, ph != P_IDLE};
    endfunction

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        tc = 1'b1;
        step();
        checks++;
        if (obs_v !== IDLE_V) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs_v, IDLE_V);
        end
        checks++;
        if (EOP_out_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_eop_out got=%b exp=1", EOP_out_n);
        end
        idle_inputs();
    endtask

    task automatic test_write_single();
        logic [12:0] exp_v [0:7];
        exp_v = '{13'b1_0000_0_0_1111_0_1, 13'b1_0000_0_0_1111_0_1, 13'b1_0000_0_0_1111_0_1,
                  13'b1_0100_1_1_1111_0_1, 13'b1_0100_1_0_1101_0_1, 13'b1_0100_1_0_1001_0_1,
                  13'b1_0100_1_0_1111_1_1, IDLE_V};
        idle_inputs();
        req_valid = 1'b1; req_ch = 2'd2; xfer_type = 2'b01; HLDA = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            req_valid = 1'b0;
            req_ch    = 2'd1;
            xfer_type = 2'b10;
            HLDA      = (i >= 2);
            checks++;
            if (obs_v !== exp_v[i] || EOP_out_n !== 1'b1) begin
                failures++;
                $display("FAIL write_single[%0d] got=%b eop=%b exp=%b eop=1", i, obs_v, EOP_out_n, exp_v[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_read_wait();
        logic [12:0] exp_v [0:7];
        exp_v = '{13'b1_0000_0_0_1111_0_1, 13'b1_0010_1_1_1111_0_1, 13'b1_0010_1_0_0111_0_1,
                  13'b1_0010_1_0_0110_0_1, 13'b1_0010_1_0_0110_0_1, 13'b1_0010_1_0_0110_0_1,
                  13'b1_0010_1_0_1111_1_1, IDLE_V};
        idle_inputs();
        req_valid = 1'b1; req_ch = 2'd1; xfer_type = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step();
            req_valid = 1'b0;
            READY     = !(i == 3 || i == 4);
            checks++;
            if (obs_v !== exp_v[i]) begin
                failures++;
                $display("FAIL read_wait[%0d] got=%b exp=%b", i, obs_v, exp_v[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_block_tc();
        idle_inputs();
        req_valid = 1'b1; req_ch = 2'd3; xfer_type = 2'b01; blk_mode = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            logic s4, s1, act;
            step();
            req_valid = 1'b0;
            s4  = (cyc >= 5) && (cyc <= 13) && ((cyc - 1) % 4 == 0);
            s1  = (cyc >= 2) && (cyc <= 10) && ((cyc - 2) % 4 == 0);
            act = (cyc <= 13);
            tc  = (cyc == 13);
            #1;
            checks++;
            if (update !== s4 || ADSTB !== s1 || busy !== act || HRQ !== act ||
                EOP_out_n !== !(cyc == 13)) begin
                failures++;
                $display("FAIL block_tc[%0d] got upd=%b adstb=%b busy=%b hrq=%b eop=%b exp %b %b %b %b %b",
                         cyc, update, ADSTB, busy, HRQ, EOP_out_n, s4, s1, act, act, !(cyc == 13));
            end
        end
        idle_inputs();
    endtask

    task automatic test_eop_block();
        idle_inputs();
        req_valid = 1'b1; req_ch = 2'd0; xfer_type = 2'b10; blk_mode = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            req_valid = 1'b0;
            EOP_in_n  = !(cyc == 3);
            #1;
            checks++;
            if (update !== (cyc == 5) || busy !== (cyc <= 5) || EOP_out_n !== 1'b1 ||
                ADSTB !== (cyc == 2)) begin
                failures++;
                $display("FAIL eop_block[%0d] got upd=%b busy=%b eop=%b adstb=%b exp %b %b 1 %b",
                         cyc, update, busy, EOP_out_n, ADSTB, cyc == 5, cyc <= 5, cyc == 2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_abort_and_reset();
        logic [12:0] exp_v [0:5];
        logic [12:0] exp_r [0:6];
        exp_v = '{13'b1_0000_0_0_1111_0_1, 13'b1_0010_1_1_1111_0_1, 13'b1_0010_1_0_1101_0_1,
                  13'b1_0010_1_0_1001_0_1, IDLE_V, IDLE_V};
        idle_inputs();
        req_valid = 1'b1; req_ch = 2'd1; xfer_type = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            req_valid = 1'b0;
            HLDA      = (i < 3);
            checks++;
            if (obs_v !== exp_v[i]) begin
                failures++;
                $display("FAIL hlda_drop[%0d] got=%b exp=%b", i, obs_v, exp_v[i]);
            end
        end
        exp_r = '{13'b1_0000_0_0_1111_0_1, 13'b1_1000_1_1_1111_0_1, 13'b1_1000_1_0_0111_0_1,
                  13'b1_1000_1_0_0110_0_1, 13'b1_1000_1_0_0110_0_1, IDLE_V, IDLE_V};
        idle_inputs();
        req_valid = 1'b1; req_ch = 2'd3; xfer_type = 2'b10;
        for (int i = 0; i < 7; i++) begin
            step();
            req_valid = 1'b0;
            READY     = !(i == 3 || i == 4);
            RESET     = (i == 4);
            checks++;
            if (obs_v !== exp_r[i] || EOP_out_n !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_sw[%0d] got=%b eop=%b exp=%b eop=1", i, obs_v, EOP_out_n, exp_r[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_disable_verify();
        idle_inputs();
        req_valid = 1'b1; cmd_disable = 1'b1; req_ch = 2'd2; xfer_type = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_v !== IDLE_V) begin
                failures++;
                $display("FAIL disabled[%0d] got=%b exp=%b", i, obs_v, IDLE_V);
            end
        end
        cmd_disable = 1'b0; req_ch = 2'd0; xfer_type = 2'b11;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            logic [3:0] dk;
            step();
            req_valid = 1'b0;
            dk = (cyc >= 2 && cyc <= 5) ? 4'b0001 : 4'b0000;
            checks++;
            if ({MEMR_n, MEMW_n, IOR_n, IOW_n} !== 4'b1111 || update !== (cyc == 5) ||
                busy !== (cyc <= 5) || dack_en !== dk) begin
                failures++;
                $display("FAIL verify11[%0d] got cmds=%b upd=%b busy=%b dack=%b exp 1111 %b %b %b",
                         cyc, {MEMR_n, MEMW_n, IOR_n, IOW_n}, update, busy, dack_en, cyc == 5, cyc <= 5, dk);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int         ph;
        logic [1:0] m_ch;
        logic [1:0] m_ty;
        logic       m_blk;
        logic       m_eop;
        logic [12:0] exp_v;
        logic        exp_eop;
        int          local_fail;
        local_fail = 0;
        step();
        idle_inputs();
        RESET = 1'b1;
        ph = P_IDLE; m_ch = 2'd0; m_ty = 2'b00; m_blk = 1'b0; m_eop = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            exp_v = model_out(ph, m_ch, m_ty);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                local_fail++;
                if (local_fail < 10) $display("FAIL random_out[%0d] got=%b exp=%b", i, obs_v, exp_v);
            end
            RESET       = ($urandom_range(0, 149) == 0);
            req_valid   = $urandom_range(0, 1);
            req_ch      = $urandom_range(0, 3);
            cmd_disable = ($urandom_range(0, 3) == 0);
            xfer_type   = $urandom_range(0, 3);
            blk_mode    = $urandom_range(0, 1);
            HLDA        = ($urandom_range(0, 15) != 0);
            READY       = ($urandom_range(0, 3) != 0);
            tc          = ($urandom_range(0, 3) == 0);
            EOP_in_n    = ($urandom_range(0, 19) != 0);
            #1;
            exp_eop = !(ph == P_DONE && tc);
            checks++;
            if (EOP_out_n !== exp_eop) begin
                failures++;
                local_fail++;
                if (local_fail < 10) $display("FAIL random_eop[%0d] got=%b exp=%b", i, EOP_out_n, exp_eop);
            end
            // Advance the model by the edge that will consume these inputs.
            if (RESET) begin
                ph = P_IDLE; m_eop = 1'b0;
            end else if (ph == P_IDLE) begin
                if (req_valid && !cmd_disable) begin
                    ph = P_HOLD; m_ch = req_ch; m_ty = xfer_type; m_blk = blk_mode; m_eop = 1'b0;
                end
            end else if (ph == P_HOLD) begin
                if (HLDA) ph = P_ADDR;
            end else if (ph == P_DONE) begin
                if (!EOP_in_n) m_eop = 1'b1;
                if (tc || m_eop || !m_blk) begin
                    ph = P_IDLE; m_eop = 1'b0;
                end else begin
                    ph = P_ADDR;
                end
            end else begin
                if (!EOP_in_n) m_eop = 1'b1;
                if (!HLDA) begin
                    ph = P_IDLE; m_eop = 1'b0;
                end else if (ph == P_ADDR) begin
                    ph = P_RDCMD;
                end else if (ph == P_RDCMD) begin
                    ph = P_XFER;
                end else if (READY) begin
                    ph = P_DONE;
                end else begin
                    ph = P_WAIT;
                end
            end
        end
        idle_inputs();
        RESET = 1'b1;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_single();
        test_read_wait();
        test_block_tc();
        test_eop_block();
        test_abort_and_reset();
        test_disable_verify();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_timing_fsm.md
DMA_TIMING_FSM -- requirements
Module: dma_timing_fsm

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  priority stage has a winning, unmasked channel request.
REQ-004 req_ch  input  2  winning channel number, valid when req_valid=1.
REQ-005 cmd_disable  input  1  command register controller-disable bit; 1 blocks new services.
REQ-006 xfer_type  input  2  mode bits of granted channel: 00 verify, 01 write (I/O->mem), 10 read (mem->I/O), 11 treated as verify.
REQ-007 blk_mode  input  1  1 = block transfer, 0 = single transfer.
REQ-008 HLDA  input  1  hold acknowledge from CPU.
REQ-009 READY  input  1  memory/I/O ready; 0 inserts wait states.
REQ-010 tc  input  1  terminal count from count register, valid in S4.
REQ-011 EOP_in_n  input  1  external end-of-process, active low.
REQ-012 HRQ  output  1  hold request to CPU.
REQ-013 dack_en  output  4  one-hot internal acknowledge (polarity applied downstream).
REQ-014 AEN  output  1  address enable.
REQ-015 ADSTB  output  1  address strobe.
REQ-016 MEMR_n, MEMW_n, IOR_n, IOW_n  output  1 each  active-low commands.
REQ-017 EOP_out_n  output  1  active-low end-of-process.
REQ-018 update  output  1  one-cycle pulse: increment address / decrement count.
REQ-019 busy  output  1  1 whenever state is not SI.

Function
REQ-020 States SI, S0, S1, S2, S3, SW, S4; outputs decoded from registered state and latched channel/type only.
REQ-021 SI: if req_valid=1 and cmd_disable=0, latch req_ch, xfer_type, blk_mode; next S0; else stay SI.
REQ-022 S0: HRQ=1; HLDA=1 -> S1; else stay S0 (no timeout).
REQ-023 HRQ SHALL be 1 in S0 through S4 and SW, 0 in SI.
REQ-024 S1: AEN=1, ADSTB=1 for exactly this one cycle; next S2.
REQ-025 dack_en[latched ch]=1 in S1, S2, S3, SW, S4; all other bits 0; all 0 in SI/S0.
REQ-026 AEN=1 in S1 through S4 and SW.
REQ-027 S2: read command asserted -- write type: IOR_n=0; read type: MEMR_n=0; verify: none; next S3.
REQ-028 S3: read command held, write command asserted -- write type: MEMW_n=0; read type: IOW_n=0; READY=0 -> SW, else S4.
REQ-029 SW: all S3 commands held; READY=1 -> S4, else stay SW.
REQ-030 S4: all commands deasserted; update=1 for this cycle only (all types including verify).
REQ-031 EOP_in_n sampled low in any of S1..S4/SW sets an internal eop flag, cleared on entry to SI.
REQ-032 S4 exit: tc=1 or eop flag=1 or blk_mode=0 -> SI; otherwise (block, no TC, no EOP) -> S1.
REQ-033 EOP_out_n=0 in S4 when tc=1, else 1.
REQ-034 HLDA sampled 0 in S1, S2, S3 or SW -> SI next cycle, no update pulse, all outputs inactive.
REQ-035 req_valid changes after leaving SI SHALL NOT affect latched channel or type.

Reset
REQ-036 RESET=1 at a clock edge -> state SI, eop flag 0, HRQ=0, dack_en=0000, AEN=0, ADSTB=0, update=0, all *_n outputs=1, busy=0; RESET dominates any state including mid-transfer.

Verification
REQ-037 req_valid=1, req_ch=2, write, single, HLDA after 3 cycles, READY=1, tc=0 -> HRQ 1 in S0, ADSTB one cycle, IOR_n=0 S2-S3, MEMW_n=0 S3, dack_en=0100, one update pulse, SI after S4.
REQ-038 read type, READY=0 for 2 cycles in S3 -> two SW cycles with MEMR_n=0 and IOW_n=0 held, then S4 with single update.
REQ-039 block mode, tc=1 on third S4 -> three update pulses, S4->S1 twice, EOP_out_n=0 on third S4 only, then SI with HRQ=0.
REQ-040 block mode, EOP_in_n pulsed low in S2 of first transfer -> exit to SI after that S4, exactly one update, EOP_out_n stays 1.
REQ-041 HLDA dropped in S3 -> SI next cycle, no update, all commands 1; RESET asserted in SW -> all outputs at reset values next cycle.
REQ-042 cmd_disable=1 with req_valid=1 -> remains SI, HRQ=0; xfer_type=11 -> full cycle with no command strobes, one update.
